// File: rtl/digit_scan_counter_pkg.sv
// rtl/digit_scan_counter_pkg.sv - shared constants and helpers for the digit scan counter
// Contents:
//   DIGIT_W, SCAN_DATA_W        digit width and decoder input width
//   default_lfsr_taps(width)    maximal-length Galois tap mask (right-shift form)
//   digit_step(d, up, modulus)  one-digit increment/decrement, returns {carry, digit}
package digit_scan_counter_pkg;

    localparam int DIGIT_W     = 4;
    localparam int SCAN_DATA_W = 5;

    function automatic logic [31:0] default_lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

    // Carry/borrow is only meaningful when the digit is actually stepped;
    // the caller gates the call with the incoming carry.
    function automatic logic [DIGIT_W:0] digit_step(
        input logic [DIGIT_W-1:0] d,
        input logic               up,
        input logic [DIGIT_W:0]   modulus
    );
        logic [DIGIT_W:0] top_val;
        logic [DIGIT_W:0] result;
        top_val = modulus - (DIGIT_W+1)'(1);
        if (up) begin
            if ({1'b0, d} == top_val) begin
                result = {1'b1, {DIGIT_W{1'b0}}};
            end else begin
                result = {1'b0, d + DIGIT_W'(1)};
            end
        end else begin
            if (d == '0) begin
                result = {1'b1, top_val[DIGIT_W-1:0]};
            end else begin
                result = {1'b0, d - DIGIT_W'(1)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - Galois LFSR advanced by a step strobe
// Ports:
//   clk, rst   clock, synchronous active-high reset (loads LFSR_SEED)
//   step       advance one Galois step this edge
//   state      current LFSR state
module lfsr_galois
    import digit_scan_counter_pkg::*;
#(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(default_lfsr_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] shifted;
    logic [LFSR_W-1:0] next_state;

    assign shifted    = state >> 1;
    assign next_state = state[0] ? (shifted ^ LFSR_TAPS) : shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (state == '0) begin
            // All-zero is a lock-up state for an XOR LFSR; recover regardless of step.
            state <= LFSR_SEED;
        end else if (step) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/digit_scan_counter.sv
// rtl/digit_scan_counter.sv - period ticker driving a multi-digit up/down counter with scanned display output
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            period counter enable
//   clear         synchronous clear of period counter and digits
//   mode_rand     0 = fixed period (MAX_COUNT), 1 = LFSR-derived period
//   up_down       1 = count up, 0 = count down
//   hex_mode      forwarded as bit 4 of scan_data_o
//   tick_o        one-cycle pulse per elapsed period
//   overflow_o    one-cycle pulse when the whole digit chain wraps
//   digits_o      all digits, digit 0 in bits [3:0]
//   scan_sel_o    one-hot active digit select
//   scan_data_o   {hex_mode, active digit}
//   lfsr_o        current LFSR state
module digit_scan_counter
    import digit_scan_counter_pkg::*;
#(
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  MAX_COUNT  = CNT_W'(10000),
    parameter int                NUM_DIGITS = 4,
    parameter int                DIGIT_MOD  = 10,
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(default_lfsr_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(1),
    parameter logic [CNT_W-1:0]  RAND_BASE  = CNT_W'(16'h2000),
    parameter int                RAND_SHIFT = 5,
    parameter int                SCAN_DIV   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          mode_rand,
    input  logic                          up_down,
    input  logic                          hex_mode,
    output logic                          tick_o,
    output logic                          overflow_o,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]         scan_sel_o,
    output logic [SCAN_DATA_W-1:0]        scan_data_o,
    output logic [LFSR_W-1:0]             lfsr_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIGIT_W:0] MOD_V = (DIGIT_W+1)'(DIGIT_MOD);

    // ---------------- period counter ----------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rand_cmp;
    logic [CNT_W-1:0] cmp;
    logic             hit;
    logic             lfsr_step;

    // Truncation to CNT_W is intentional: the random period wraps within the counter width.
    assign rand_cmp  = RAND_BASE + (CNT_W'(lfsr_o) << RAND_SHIFT);
    assign cmp       = mode_rand ? rand_cmp : MAX_COUNT;
    // >= rather than == so a compare lowered below cnt ends the period immediately.
    assign hit       = (cnt >= cmp);
    assign lfsr_step = en & hit & ~clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else if (en) begin
            if (hit) begin
                cnt    <= '0;
                tick_o <= 1'b1;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_o <= 1'b0;
            end
        end else begin
            tick_o <= 1'b0;
        end
    end

    lfsr_galois #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_o)
    );

    // ---------------- digit chain ----------------
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_next;
    logic [DIGIT_W:0]                   step_res;
    logic                               chain_carry;

    // Ripple: each digit steps only when everything below it wrapped.
    // Carry out of the top digit leaves the chain already wrapped.
    always_comb begin
        digits_next = digits_q;
        step_res    = '0;
        chain_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (chain_carry) begin
                step_res       = digit_step(digits_q[i], up_down, MOD_V);
                digits_next[i] = step_res[DIGIT_W-1:0];
                chain_carry    = step_res[DIGIT_W];
            end
        end
    end

    // Digits follow tick_o by one cycle; clear discards a same-cycle pending update.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits_q   <= '0;
            overflow_o <= 1'b0;
        end else if (tick_o) begin
            digits_q   <= digits_next;
            overflow_o <= chain_carry;
        end else begin
            overflow_o <= 1'b0;
        end
    end

    assign digits_o = digits_q;

    // ---------------- display scan ----------------
    logic [IDX_W-1:0] scan_idx;
    logic [DIV_W-1:0] scan_div;

    // Free-running: the display keeps refreshing while counting is disabled or cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_div   <= '0;
            scan_idx   <= '0;
            scan_sel_o <= NUM_DIGITS'(1);
        end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
            scan_div   <= '0;
            scan_idx   <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            scan_sel_o <= (scan_sel_o << 1) | (scan_sel_o >> (NUM_DIGITS - 1));
        end else begin
            scan_div   <= scan_div + DIV_W'(1);
        end
    end

    assign scan_data_o = {hex_mode, digits_q[scan_idx]};

endmodule

// File: tb/tb_digit_scan_counter.sv
// tb/tb_digit_scan_counter.sv - self-checking bench for digit_scan_counter
module tb_digit_scan_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1;
    logic clear = 1'b0;
    logic mode_rand = 1'b0;
    logic up_down = 1'b1;
    logic hex_mode = 1'b0;

    // small instance: 2 digits, short fixed period, random period = 4 + lfsr
    logic       a_tick, a_ovf;
    logic [7:0] a_digits;
    logic [1:0] a_sel;
    logic [4:0] a_data;
    logic [7:0] a_lfsr;

    // default instance: MAX_COUNT=10000, RAND_BASE=0x2000, RAND_SHIFT=5
    logic        c_tick, c_ovf;
    logic [15:0] c_digits;
    logic [3:0]  c_sel;
    logic [4:0]  c_data;
    logic [7:0]  c_lfsr;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] sb_q[$];
    logic [6:0] scan_q[$];

    always #5 clk = ~clk;

    digit_scan_counter #(
        .CNT_W(16), .MAX_COUNT(16'd3), .NUM_DIGITS(2), .DIGIT_MOD(10),
        .LFSR_W(8), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01),
        .RAND_BASE(16'd4), .RAND_SHIFT(0), .SCAN_DIV(2)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode_rand(mode_rand),
        .up_down(up_down), .hex_mode(hex_mode), .tick_o(a_tick), .overflow_o(a_ovf),
        .digits_o(a_digits), .scan_sel_o(a_sel), .scan_data_o(a_data), .lfsr_o(a_lfsr)
    );

    digit_scan_counter u_c (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .mode_rand(mode_rand),
        .up_down(up_down), .hex_mode(hex_mode), .tick_o(c_tick), .overflow_o(c_ovf),
        .digits_o(c_digits), .scan_sel_o(c_sel), .scan_data_o(c_data), .lfsr_o(c_lfsr)
    );

    function automatic logic [7:0] gal(input logic [7:0] s);
        logic [7:0] sh;
        sh = s >> 1;
        return s[0] ? (sh ^ 8'hB8) : sh;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int c_rand_cmp(input logic [7:0] l);
        logic [15:0] r;
        r = 16'h2000 + (16'(l) << 5);
        return int'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; clear = 1'b0; mode_rand = 1'b0; up_down = 1'b1; hex_mode = 1'b0;
        do_reset();
        vectors++; if (a_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b want 0", a_tick); end
        vectors++; if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
        vectors++; if (a_digits !== 8'h00) begin miscompares++; $display("FAIL reset_digits got %h want 00", a_digits); end
        vectors++; if (a_sel !== 2'b01) begin miscompares++; $display("FAIL reset_sel got %b want 01", a_sel); end
        vectors++; if (a_lfsr !== 8'h01) begin miscompares++; $display("FAIL reset_lfsr got %h want 01", a_lfsr); end
        vectors++; if (a_data !== 5'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", a_data); end
        vectors++; if (c_sel !== 4'b0001) begin miscompares++; $display("FAIL reset_c_sel got %b want 0001", c_sel); end
        vectors++; if (c_digits !== 16'h0000) begin miscompares++; $display("FAIL reset_c_digits got %h want 0000", c_digits); end
    endtask

    task automatic test_enable();
        int ticks;
        int since;
        en = 1'b0; up_down = 1'b1; mode_rand = 1'b0;
        do_reset();
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_tick) ticks++;
        end
        vectors++; if (ticks != 0) begin miscompares++; $display("FAIL en_low_ticks got %0d want 0", ticks); end
        en = 1'b1;
        since = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            since++;
            if (a_tick) break;
        end
        vectors++; if (since != 4 || !a_tick) begin miscompares++; $display("FAIL en_resume_period got %0d want 4", since); end
    endtask

    // Runs the small instance for n_ticks periods, checking period length
    // and the digit/overflow value the cycle after every tick.
    task automatic run_ticks(input int n_ticks, input bit up);
        int model_val, since, ticks, exp_ovf, seen_ovf;
        logic [8:0] exp;
        logic ovf;
        model_val = 0; since = 0; ticks = 0; exp_ovf = 0; seen_ovf = 0;
        sb_q.delete();
        for (int c = 0; c < n_ticks * 4 + 20; c++) begin
            if (ticks == n_ticks && sb_q.size() == 0) break;
            step();
            since++;
            if (a_ovf) seen_ovf++;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                vectors++;
                if ({a_ovf, a_digits} !== exp)
                    begin miscompares++; $display("FAIL digits_after_tick got ovf=%b dig=%h want ovf=%b dig=%h", a_ovf, a_digits, exp[8], exp[7:0]); end
            end
            if (a_tick) begin
                vectors++;
                if (since != 4) begin miscompares++; $display("FAIL tick_period got %0d want 4", since); end
                since = 0;
                ticks++;
                ovf = 1'b0;
                if (up) begin
                    model_val = (model_val + 1) % 100;
                    ovf = (model_val == 0);
                end else if (model_val == 0) begin
                    model_val = 99;
                    ovf = 1'b1;
                end else begin
                    model_val = model_val - 1;
                end
                if (ovf) exp_ovf++;
                sb_q.push_back({ovf, to_bcd2(model_val)});
            end
        end
        vectors++;
        if (ticks != n_ticks || sb_q.size() != 0) begin miscompares++; $display("FAIL run_ticks_timeout got %0d ticks want %0d", ticks, n_ticks); end
        vectors++;
        if (seen_ovf != exp_ovf) begin miscompares++; $display("FAIL overflow_pulses got %0d want %0d", seen_ovf, exp_ovf); end
    endtask

    task automatic test_count_up();
        en = 1'b1; mode_rand = 1'b0; up_down = 1'b1;
        do_reset();
        run_ticks(100, 1'b1);
        vectors++; if (a_digits !== 8'h00) begin miscompares++; $display("FAIL up_wrap_digits got %h want 00", a_digits); end
    endtask

    task automatic test_count_down();
        en = 1'b1; mode_rand = 1'b0; up_down = 1'b0;
        do_reset();
        run_ticks(2, 1'b0);
        up_down = 1'b1;
    endtask

    task automatic test_random_period();
        logic [7:0] lm;
        int since, exp_period;
        en = 1'b1; mode_rand = 1'b1; up_down = 1'b1;
        do_reset();
        lm = 8'h01;
        for (int k = 0; k < 3; k++) begin
            exp_period = 4 + int'(lm) + 1;
            lm = gal(lm);
            since = 0;
            for (int i = 0; i < 400; i++) begin
                step();
                since++;
                if (a_tick) break;
            end
            vectors++;
            if (!a_tick || since != exp_period) begin miscompares++; $display("FAIL rand_period[%0d] got %0d want %0d", k, since, exp_period); end
            vectors++;
            if (a_lfsr !== lm) begin miscompares++; $display("FAIL rand_lfsr[%0d] got %h want %h", k, a_lfsr, lm); end
        end
        mode_rand = 1'b0;
    endtask

    task automatic test_mode_switch();
        int early, first_tick, exp_first;
        en = 1'b1; mode_rand = 1'b0; up_down = 1'b1;
        do_reset();
        early = 0;
        for (int n = 1; n <= 2000; n++) begin
            step();
            if (c_tick) early++;
        end
        mode_rand = 1'b1;
        exp_first = c_rand_cmp(8'h01) + 1;
        first_tick = -1;
        for (int n = 2001; n <= 9000; n++) begin
            step();
            if (c_tick) begin first_tick = n; break; end
        end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL switch_early_ticks got %0d want 0", early); end
        vectors++; if (first_tick != exp_first) begin miscompares++; $display("FAIL switch_first_tick got %0d want %0d", first_tick, exp_first); end
        vectors++; if (c_lfsr !== gal(8'h01)) begin miscompares++; $display("FAIL switch_lfsr got %h want %h", c_lfsr, gal(8'h01)); end
        // Random compare is now above 11000; climb past the fixed 10000 then drop to fixed.
        early = 0;
        for (int n = 0; n < 11000; n++) begin
            step();
            if (c_tick) early++;
        end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL switch_hold_ticks got %0d want 0", early); end
        mode_rand = 1'b0;
        step();
        vectors++; if (c_tick !== 1'b1) begin miscompares++; $display("FAIL switch_lower_tick got %b want 1", c_tick); end
    endtask

    task automatic test_clear();
        logic [7:0] lm;
        int ticks;
        en = 1'b1; mode_rand = 1'b0; up_down = 1'b1;
        do_reset();
        lm = 8'h01;
        ticks = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (a_tick) begin
                ticks++;
                lm = gal(lm);
                if (ticks == 38) break;
            end
        end
        vectors++; if (ticks != 38 || a_digits !== 8'h37) begin miscompares++; $display("FAIL clear_setup got ticks=%0d dig=%h want 38/37", ticks, a_digits); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        vectors++; if (a_digits !== 8'h00) begin miscompares++; $display("FAIL clear_digits got %h want 00", a_digits); end
        vectors++; if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL clear_ovf got %b want 0", a_ovf); end
        vectors++; if (a_tick !== 1'b0) begin miscompares++; $display("FAIL clear_tick got %b want 0", a_tick); end
        vectors++; if (a_lfsr !== lm) begin miscompares++; $display("FAIL clear_lfsr got %h want %h", a_lfsr, lm); end
    endtask

    task automatic test_scan();
        logic [7:0] bcd;
        logic [3:0] dig;
        logic [1:0] sel;
        int v, idx;
        logic [6:0] exp;
        en = 1'b1; mode_rand = 1'b0; up_down = 1'b1; hex_mode = 1'b0;
        do_reset();
        scan_q.delete();
        for (int n = 0; n < 42; n++) begin
            hex_mode = 1'($urandom_range(0, 1));
            v = (n / 4) % 100;
            idx = ((n + 1) / 2) % 2;
            bcd = to_bcd2(v);
            dig = (idx == 1) ? bcd[7:4] : bcd[3:0];
            sel = (idx == 1) ? 2'b10 : 2'b01;
            scan_q.push_back({sel, hex_mode, dig});
            step();
            exp = scan_q.pop_front();
            vectors++;
            if ({a_sel, a_data} !== exp) begin miscompares++; $display("FAIL scan[%0d] got sel=%b data=%h want sel=%b data=%h", n, a_sel, a_data, exp[6:5], exp[4:0]); end
        end
        do_reset();
        vectors++; if (a_sel !== 2'b01) begin miscompares++; $display("FAIL scan_reset_sel got %b want 01", a_sel); end
        vectors++; if (a_data !== {hex_mode, 4'h0}) begin miscompares++; $display("FAIL scan_reset_data got %h want %h", a_data, {hex_mode, 4'h0}); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_count_up();
        test_count_down();
        test_random_period();
        test_mode_switch();
        test_clear();
        test_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
